// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//
// Multi-cycle control FSM for an RV32 datapath subset: R-type, I-type ALU,
// LW, SW and BEQ. It steps the shared ALU, the register file and one
// unified memory port through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Every memory access uses a request/ready handshake. An illegal opcode or
// a memory timeout sends the FSM to a sticky FAULT state.
//
// Optional build macro: SEQUENCER_PERF_COUNTERS_EN adds the retiredCount
// and stallCount performance counter outputs.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   opcode/funct3/funct7   instruction fields, valid from DECODE onward
//   aluZero                ALU zero flag, used by BEQ in EXECUTE
//   memoryReady            memory completes the current access this cycle
//   memoryRequest          memory access request (fetch, LW, SW)
//   memoryWriteEnable      request is a write (SW)
//   addressSource          0 = PC, 1 = ALU result register
//   instructionWriteEnable load instruction register
//   pcWriteEnable          PC <= PC + 4
//   pcBranchWrite          PC <= branch target
//   registerWriteEnable    register file write
//   aluInputSource         0 = register B, 1 = immediate
//   resultSource           0 = ALU result, 1 = memory data
//   aluControlSignal       000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
//   fault                  sticky fault indication
//   state                  current state encoding (debug)
//   retiredCount           (optional) retired instruction count
//   stallCount             (optional) memory stall cycle count
//
// state     | meaning
// ----------+-------------------------------------------------------------
// FETCH     | read instruction at PC; on ready load IR and advance PC
// DECODE    | latch opcode/funct fields, trap illegal opcodes
// EXECUTE   | drive the ALU; BEQ resolves the branch here
// MEMORY    | LW/SW data access through the shared memory port
// WRITEBACK | write ALU result or load data to the register file
// FAULT     | illegal opcode or memory timeout; only reset leaves it

module multicycle_sequencer #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int TIMEOUT_WIDTH = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       aluZero,
    input  logic       memoryReady,
    output logic       memoryRequest,
    output logic       memoryWriteEnable,
    output logic       addressSource,
    output logic       instructionWriteEnable,
    output logic       pcWriteEnable,
    output logic       pcBranchWrite,
    output logic       registerWriteEnable,
    output logic       aluInputSource,
    output logic       resultSource,
    output logic [2:0] aluControlSignal,
    output logic       fault,
`ifdef SEQUENCER_PERF_COUNTERS_EN
    output logic [31:0] retiredCount,
    output logic [31:0] stallCount,
`endif
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd7
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Last count value that still allows another wait cycle; a wait cycle
    // seen at this count is the MEM_TIMEOUT-th one.
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [6:0]               opcode_q;
    logic [2:0]               funct3_q;
    logic [6:0]               funct7_q;
    logic                     mem_phase;
    logic                     mem_wait;
    logic                     timed_out;
    logic                     unused_funct7;

    // Only funct7[5] selects SUB; the other bits are latched for debug.
    assign unused_funct7 = ^{funct7_q[6], funct7_q[4:0]};

    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
    assign mem_wait  = mem_phase && !memoryReady;
    // Ready in the final allowed cycle still completes the handshake.
    assign timed_out = mem_wait && (timeout_q == TIMEOUT_LAST);

    function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_map = sub ? ALU_SUB : ALU_ADD;
            3'b010:  alu_map = ALU_SLT;
            3'b100:  alu_map = ALU_XOR;
            3'b110:  alu_map = ALU_OR;
            3'b111:  alu_map = ALU_AND;
            default: alu_map = ALU_ADD;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter only advances on a wait cycle. Any other cycle, including
    // the handshake and every cycle outside FETCH/MEMORY, clears it. So it
    // is already zero each time FETCH or MEMORY is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
        end else begin
            if (mem_wait) begin
                timeout_q <= timeout_q + 1'b1;
            end else begin
                timeout_q <= '0;
            end
            if (state_q == ST_DECODE) begin
                opcode_q <= opcode;
                funct3_q <= funct3;
                funct7_q <= funct7;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (memoryReady) begin
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                // The fields are being latched in this cycle, so legality is
                // checked on the live opcode input.
                case (opcode)
                    OP_RTYPE, OP_ITYPE, OP_LW, OP_SW, OP_BEQ: state_d = ST_EXECUTE;
                    default:                                  state_d = ST_FAULT;
                endcase
            end
            ST_EXECUTE: begin
                case (opcode_q)
                    OP_RTYPE, OP_ITYPE: state_d = ST_WRITEBACK;
                    OP_LW, OP_SW:       state_d = ST_MEMORY;
                    OP_BEQ:             state_d = ST_FETCH;
                    default:            state_d = ST_FAULT;
                endcase
            end
            ST_MEMORY: begin
                if (memoryReady) begin
                    state_d = (opcode_q == OP_LW) ? ST_WRITEBACK : ST_FETCH;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_FAULT;
        endcase
    end

    // Output logic
    always_comb begin
        memoryRequest          = 1'b0;
        memoryWriteEnable      = 1'b0;
        addressSource          = 1'b0;
        instructionWriteEnable = 1'b0;
        pcWriteEnable          = 1'b0;
        pcBranchWrite          = 1'b0;
        registerWriteEnable    = 1'b0;
        aluInputSource         = 1'b0;
        resultSource           = 1'b0;
        aluControlSignal       = ALU_ADD;
        fault                  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                memoryRequest = 1'b1;
                // Reset holds the FSM in FETCH, so a ready seen during reset
                // must not load IR or move the PC.
                instructionWriteEnable = memoryReady && !reset;
                pcWriteEnable          = memoryReady && !reset;
            end
            ST_EXECUTE: begin
                case (opcode_q)
                    OP_RTYPE: begin
                        aluInputSource   = 1'b0;
                        aluControlSignal = alu_map(funct3_q, funct7_q[5]);
                    end
                    OP_ITYPE: begin
                        aluInputSource   = 1'b1;
                        aluControlSignal = alu_map(funct3_q, 1'b0);
                    end
                    OP_LW, OP_SW: begin
                        aluInputSource   = 1'b1;
                        aluControlSignal = ALU_ADD;
                    end
                    OP_BEQ: begin
                        aluControlSignal = ALU_SUB;
                        pcBranchWrite    = aluZero;
                    end
                    default: ;
                endcase
            end
            ST_MEMORY: begin
                memoryRequest     = 1'b1;
                addressSource     = 1'b1;
                memoryWriteEnable = (opcode_q == OP_SW);
            end
            ST_WRITEBACK: begin
                registerWriteEnable = 1'b1;
                resultSource        = (opcode_q == OP_LW);
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef SEQUENCER_PERF_COUNTERS_EN
    logic retire;
    logic stall;

    // Only SW leaves MEMORY for FETCH and only BEQ leaves EXECUTE for FETCH.
    assign retire = (state_d == ST_FETCH) &&
                    ((state_q == ST_WRITEBACK) || (state_q == ST_MEMORY) ||
                     (state_q == ST_EXECUTE));
    assign stall  = memoryRequest && !memoryReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retiredCount <= '0;
            stallCount   <= '0;
        end else begin
            if (retire) retiredCount <= retiredCount + 32'd1;
            if (stall)  stallCount   <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

    localparam int TO = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010,
                           OR_ = 3'b011, XOR_ = 3'b100, SLT = 3'b101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       aluZero = 1'b0;
    logic       memoryReady = 1'b0;
    logic       memoryRequest, memoryWriteEnable, addressSource;
    logic       instructionWriteEnable, pcWriteEnable, pcBranchWrite;
    logic       registerWriteEnable, aluInputSource, resultSource, fault;
    logic [2:0] aluControlSignal;
    logic [2:0] state;
`ifdef SEQUENCER_PERF_COUNTERS_EN
    logic [31:0] retiredCount, stallCount;
`endif

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .TIMEOUT_WIDTH(5)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .opcode                 (opcode),
        .funct3                 (funct3),
        .funct7                 (funct7),
        .aluZero                (aluZero),
        .memoryReady            (memoryReady),
        .memoryRequest          (memoryRequest),
        .memoryWriteEnable      (memoryWriteEnable),
        .addressSource          (addressSource),
        .instructionWriteEnable (instructionWriteEnable),
        .pcWriteEnable          (pcWriteEnable),
        .pcBranchWrite          (pcBranchWrite),
        .registerWriteEnable    (registerWriteEnable),
        .aluInputSource         (aluInputSource),
        .resultSource           (resultSource),
        .aluControlSignal       (aluControlSignal),
        .fault                  (fault),
`ifdef SEQUENCER_PERF_COUNTERS_EN
        .retiredCount           (retiredCount),
        .stallCount             (stallCount),
`endif
        .state                  (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] sig;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // sig = {mreq, mwe, asrc, irwe, pcwe, pcbr, rwe, ais, rs, alu[2:0], fault}
    function automatic exp_t mk(input logic [2:0] st, input logic mreq, input logic mwe,
                                input logic asrc, input logic irwe, input logic pcwe,
                                input logic pcbr, input logic rwe, input logic ais,
                                input logic rs, input logic [2:0] alu, input logic flt);
        exp_t r;
        r.st  = st;
        r.sig = {mreq, mwe, asrc, irwe, pcwe, pcbr, rwe, ais, rs, alu, flt};
        return r;
    endfunction

    function automatic exp_t e_fetch(input logic rdy);
        return mk(3'd0, 1, 0, 0, rdy, rdy, 0, 0, 0, 0, ADD, 0);
    endfunction
    function automatic exp_t e_decode();
        return mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADD, 0);
    endfunction
    function automatic exp_t e_exec(input logic [2:0] alu, input logic ais, input logic br);
        return mk(3'd2, 0, 0, 0, 0, 0, br, 0, ais, 0, alu, 0);
    endfunction
    function automatic exp_t e_mem(input logic we);
        return mk(3'd3, 1, we, 1, 0, 0, 0, 0, 0, 0, ADD, 0);
    endfunction
    function automatic exp_t e_wb(input logic rs);
        return mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 0, rs, ADD, 0);
    endfunction
    function automatic exp_t e_fault();
        return mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADD, 1);
    endfunction

    task automatic check_out(input string tag);
        exp_t x;
        logic [12:0] obs;
        x   = q.pop_front();
        obs = {memoryRequest, memoryWriteEnable, addressSource, instructionWriteEnable,
               pcWriteEnable, pcBranchWrite, registerWriteEnable, aluInputSource,
               resultSource, aluControlSignal, fault};
        checks += 2;
        assert (state === x.st) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, x.st);
        end
        assert (obs === x.sig) else begin
            errors++;
            $error("FAIL %s strobes: got %b expected %b", tag, obs, x.sig);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare before
    // the next rising edge.
    task automatic cyc(input logic rdy, input logic zero, input exp_t e, input string tag);
        @(negedge clk);
        reset       = 1'b0;
        memoryReady = rdy;
        aluZero     = zero;
        q.push_back(e);
        #2;
        check_out(tag);
    endtask

    // Hold reset for two cycles with ready high: only memoryRequest may be set.
    task automatic do_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset       = 1'b1;
            memoryReady = 1'b1;
            aluZero     = 1'b1;
            q.push_back(e_fetch(1'b0));
            #1;
            check_out(tag);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] alu, input logic ais, input string tag);
        set_instr(op, f3, f7);
        cyc(1, 0, e_fetch(1), {tag, "_fetch"});
        cyc(1, 0, e_decode(), {tag, "_decode"});
        cyc(1, 1, e_exec(alu, ais, 0), {tag, "_exec"});
        cyc(1, 1, e_wb(0), {tag, "_wb"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("reset_init");

        // ALU ops with zero-wait memory: 4 cycles each
        run_alu(OP_R, 3'b000, 7'b0000000, ADD,  0, "add");
        run_alu(OP_R, 3'b000, 7'b0100000, SUB,  0, "sub");
        run_alu(OP_I, 3'b000, 7'b0100000, ADD,  1, "addi_f7");
        run_alu(OP_R, 3'b010, 7'b0000000, SLT,  0, "slt");
        run_alu(OP_I, 3'b100, 7'b0000000, XOR_, 1, "xori");
        run_alu(OP_R, 3'b110, 7'b0000000, OR_,  0, "or");
        run_alu(OP_R, 3'b111, 7'b0000000, AND_, 0, "and");
        run_alu(OP_I, 3'b001, 7'b0000000, ADD,  1, "i_f3_001");
        run_alu(OP_R, 3'b011, 7'b0100000, ADD,  0, "r_f3_011");

        // LW with three wait cycles in MEMORY: 8 cycles total
        set_instr(OP_LW, 3'b010, 7'b0);
        cyc(1, 0, e_fetch(1), "lw_fetch");
        cyc(1, 0, e_decode(), "lw_decode");
        cyc(0, 0, e_exec(ADD, 1, 0), "lw_exec");
        for (int i = 0; i < 3; i++) cyc(0, 0, e_mem(0), "lw_mem_wait");
        cyc(1, 0, e_mem(0), "lw_mem_done");
        cyc(0, 0, e_wb(1), "lw_wb");

        // SW zero-wait: 4 cycles
        set_instr(OP_SW, 3'b010, 7'b0);
        cyc(1, 0, e_fetch(1), "sw_fetch");
        cyc(1, 0, e_decode(), "sw_decode");
        cyc(1, 0, e_exec(ADD, 1, 0), "sw_exec");
        cyc(1, 0, e_mem(1), "sw_mem");

        // BEQ taken then not taken: 3 cycles each
        set_instr(OP_BEQ, 3'b000, 7'b0);
        cyc(1, 0, e_fetch(1), "beq1_fetch");
        cyc(1, 1, e_decode(), "beq1_decode");
        cyc(1, 1, e_exec(SUB, 0, 1), "beq1_exec");
        cyc(1, 1, e_fetch(1), "beq2_fetch");
        cyc(1, 1, e_decode(), "beq2_decode");
        cyc(1, 0, e_exec(SUB, 0, 0), "beq2_exec");

        // Fetch ready on the last allowed cycle: no fault
        set_instr(OP_R, 3'b000, 7'b0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, e_fetch(0), "fto_wait");
        cyc(1, 0, e_fetch(1), "fto_ready_last");
        cyc(1, 0, e_decode(), "fto_decode");
        cyc(1, 0, e_exec(ADD, 0, 0), "fto_exec");
        cyc(1, 0, e_wb(0), "fto_wb");

        // Fetch timeout: fault after TO waiting cycles, ready then ignored
        for (int i = 0; i < TO; i++) cyc(0, 0, e_fetch(0), "fto2_wait");
        for (int i = 0; i < 3; i++) cyc(1, 1, e_fault(), "fto2_fault");
        do_reset("reset_after_fetch_timeout");

        // Illegal opcode traps in DECODE and stays in FAULT
        set_instr(OP_BAD, 3'b111, 7'b1111111);
        cyc(1, 0, e_fetch(1), "ill_fetch");
        cyc(1, 0, e_decode(), "ill_decode");
        for (int i = 0; i < 20; i++) cyc(i[0], ~i[0], e_fault(), "ill_fault");
        do_reset("reset_after_illegal");

        // LW memory timeout
        set_instr(OP_LW, 3'b010, 7'b0);
        cyc(1, 0, e_fetch(1), "lwto_fetch");
        cyc(1, 0, e_decode(), "lwto_decode");
        cyc(0, 0, e_exec(ADD, 1, 0), "lwto_exec");
        for (int i = 0; i < TO; i++) cyc(0, 0, e_mem(0), "lwto_wait");
        cyc(1, 1, e_fault(), "lwto_fault");
        do_reset("reset_after_mem_timeout");

        // Reset in the middle of a stalled SW store
        set_instr(OP_SW, 3'b010, 7'b0);
        cyc(1, 0, e_fetch(1), "swr_fetch");
        cyc(1, 0, e_decode(), "swr_decode");
        cyc(0, 0, e_exec(ADD, 1, 0), "swr_exec");
        cyc(0, 0, e_mem(1), "swr_mem_wait");
        do_reset("reset_mid_sw");
        run_alu(OP_R, 3'b100, 7'b0000000, XOR_, 0, "xor_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
